// File: rtl/bubbledrive8_pkg.sv
// Shared types for the BubbleDrive8 power supervisor: supervisor state codes,
// LED blink modes and the state-to-LED mapping.
package bubbledrive8_pkg;

    typedef enum logic [2:0] {
        RESET_S0         = 3'b000,
        MODE_SELECT_S0   = 3'b001,
        EMULATOR_S1      = 3'b011,
        MPSSE_STANDBY_S0 = 3'b101,
        ERROR_S0         = 3'b110,
        ERROR_S1         = 3'b111
    } pwr_state_e;

    typedef enum logic [1:0] {
        BLINK_MODE_OFF  = 2'd0,
        BLINK_MODE_ON   = 2'd1,
        BLINK_MODE_FAST = 2'd2,
        BLINK_MODE_SLOW = 2'd3
    } blink_mode_e;

    // Debounced {PWRSTAT, MRST} combinations seen by the supervisor.
    localparam logic [1:0] PAIR_BOARD_OK  = 2'b00;
    localparam logic [1:0] PAIR_MRST_BAD  = 2'b01;
    localparam logic [1:0] PAIR_USB_ONLY  = 2'b10;
    localparam logic [1:0] PAIR_USB_NOBRD = 2'b11;

    function automatic blink_mode_e blink_mode_of(input pwr_state_e s);
        blink_mode_e m;
        case (s)
            EMULATOR_S1,
            MPSSE_STANDBY_S0: m = BLINK_MODE_ON;
            ERROR_S0:         m = BLINK_MODE_FAST;
            ERROR_S1:         m = BLINK_MODE_SLOW;
            default:          m = BLINK_MODE_OFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/bubbledrive8_debounce.sv
// Two-flop synchronizer followed by a level debouncer; also reports when the
// debounced level has been held for a full debounce window since reset.
module bubbledrive8_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 48000
) (
    input  logic MCLK,
    input  logic nRESET,
    input  logic async_in,
    output logic db_out,
    output logic stable
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEBOUNCE_CYCLES);

    logic          sync_1;
    logic          sync_2;
    logic          fill_1;
    logic          fill_2;
    logic [CW-1:0] chg_cnt;
    logic [CW-1:0] stable_cnt;

    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            sync_1     <= 1'b0;
            sync_2     <= 1'b0;
            fill_1     <= 1'b0;
            fill_2     <= 1'b0;
            db_out     <= 1'b0;
            chg_cnt    <= '0;
            stable_cnt <= '0;
        end else begin
            sync_1 <= async_in;
            sync_2 <= sync_1;
            fill_1 <= 1'b1;
            fill_2 <= fill_1;

            if (sync_2 == db_out) begin
                chg_cnt <= '0;
            end else if (chg_cnt == CNT_LAST) begin
                db_out  <= sync_2;
                chg_cnt <= '0;
            end else begin
                chg_cnt <= chg_cnt + 1'b1;
            end

            // Stability only counts once the synchronizer holds real samples,
            // so reset release always costs the full sync + debounce window.
            if (!fill_2 || (sync_2 != db_out)) begin
                stable_cnt <= '0;
            end else if (stable_cnt != CNT_FULL) begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

    assign stable = (stable_cnt == CNT_FULL);

endmodule

// File: rtl/bubbledrive8_pwrsup.sv
// BubbleDrive8 power supervisor: qualifies the power-mux and board-power
// inputs, then enables the emulator / temperature / USB cores and drives the power LED.
module bubbledrive8_pwrsup
    import bubbledrive8_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 48000,
    parameter int unsigned BLINK_FAST      = 4096,
    parameter int unsigned BLINK_SLOW      = 24000000
) (
    input  logic       MCLK,
    input  logic       nRESET,
    input  logic       PWRSTAT,
    input  logic       MRST,
    output logic       nEMUEN,
    output logic       nTEMPEN,
    output logic       nUSBEN,
    output logic       nLED_PWROK,
    output logic [2:0] STATE
);

    localparam int unsigned BLINK_MAX = (BLINK_SLOW > BLINK_FAST) ? BLINK_SLOW : BLINK_FAST;
    localparam int unsigned BW        = $clog2(BLINK_MAX + 1);
    localparam logic [BW-1:0] FAST_LAST = BW'(BLINK_FAST - 1);
    localparam logic [BW-1:0] SLOW_LAST = BW'(BLINK_SLOW - 1);

    logic          pwr_db;
    logic          mrst_db;
    logic          pwr_stable;
    logic          mrst_stable;
    logic          dbvalid;
    logic [1:0]    pair;

    pwr_state_e    state;
    pwr_state_e    state_q;
    blink_mode_e   led_mode;
    logic [BW-1:0] blink_cnt;
    logic [BW-1:0] blink_cnt_nxt;
    logic [BW-1:0] blink_last;
    logic          blink_phase;
    logic          blink_phase_nxt;

    bubbledrive8_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_pwrstat (
        .MCLK    (MCLK),
        .nRESET  (nRESET),
        .async_in(PWRSTAT),
        .db_out  (pwr_db),
        .stable  (pwr_stable)
    );

    bubbledrive8_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_mrst (
        .MCLK    (MCLK),
        .nRESET  (nRESET),
        .async_in(MRST),
        .db_out  (mrst_db),
        .stable  (mrst_stable)
    );

    assign pair = {pwr_db, mrst_db};

    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            dbvalid <= 1'b0;
        end else if (pwr_stable && mrst_stable) begin
            dbvalid <= 1'b1;
        end
    end

    // Blink phase 0 is LED off; a state change restarts at the off phase.
    always_comb begin
        led_mode        = blink_mode_of(state);
        blink_cnt_nxt   = blink_cnt;
        blink_phase_nxt = blink_phase;
        blink_last      = (led_mode == BLINK_MODE_SLOW) ? SLOW_LAST : FAST_LAST;
        if (state != state_q) begin
            blink_cnt_nxt   = '0;
            blink_phase_nxt = 1'b0;
        end else if ((led_mode == BLINK_MODE_FAST) || (led_mode == BLINK_MODE_SLOW)) begin
            if (blink_cnt == blink_last) begin
                blink_cnt_nxt   = '0;
                blink_phase_nxt = ~blink_phase;
            end else begin
                blink_cnt_nxt   = blink_cnt + 1'b1;
            end
        end else begin
            blink_cnt_nxt   = '0;
            blink_phase_nxt = 1'b0;
        end
    end

    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            state       <= RESET_S0;
            state_q     <= RESET_S0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            nEMUEN      <= 1'b1;
            nTEMPEN     <= 1'b1;
            nUSBEN      <= 1'b1;
            nLED_PWROK  <= 1'b1;
        end else begin
            state_q     <= state;
            blink_cnt   <= blink_cnt_nxt;
            blink_phase <= blink_phase_nxt;

            nEMUEN  <= (state != EMULATOR_S1);
            nTEMPEN <= (state != EMULATOR_S1);
            nUSBEN  <= !((state == EMULATOR_S1) || (state == MPSSE_STANDBY_S0));
            case (led_mode)
                BLINK_MODE_ON:  nLED_PWROK <= 1'b0;
                BLINK_MODE_OFF: nLED_PWROK <= 1'b1;
                default:        nLED_PWROK <= ~blink_phase_nxt;
            endcase

            case (state)
                RESET_S0: begin
                    if (dbvalid) state <= MODE_SELECT_S0;
                end
                MODE_SELECT_S0: begin
                    case (pair)
                        PAIR_BOARD_OK: state <= EMULATOR_S1;
                        PAIR_MRST_BAD: state <= ERROR_S0;
                        PAIR_USB_ONLY: state <= ERROR_S1;
                        default:       state <= MPSSE_STANDBY_S0;
                    endcase
                end
                // Losing board power while emulating drops back to requalify.
                EMULATOR_S1: begin
                    if (pair != PAIR_BOARD_OK) state <= RESET_S0;
                end
                MPSSE_STANDBY_S0: begin
                    if (pair == PAIR_BOARD_OK) state <= RESET_S0;
                end
                ERROR_S0: begin
                    if (!mrst_db) state <= RESET_S0;
                end
                ERROR_S1: begin
                    if (pair != PAIR_USB_ONLY) state <= RESET_S0;
                end
                default: state <= RESET_S0;
            endcase
        end
    end

    assign STATE = state;

endmodule

// File: tb/tb_bubbledrive8_pwrsup.sv
// Directed bench for the power supervisor with short debounce/blink windows;
// edge counts below are MCLK rising edges after an input change.
module tb_bubbledrive8_pwrsup;

    logic       MCLK;
    logic       nRESET;
    logic       PWRSTAT;
    logic       MRST;
    logic       nEMUEN;
    logic       nTEMPEN;
    logic       nUSBEN;
    logic       nLED_PWROK;
    logic [2:0] STATE;
    logic [2:0] en;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];

    bubbledrive8_pwrsup #(
        .DEBOUNCE_CYCLES(4),
        .BLINK_FAST     (3),
        .BLINK_SLOW     (6)
    ) dut (
        .MCLK      (MCLK),
        .nRESET    (nRESET),
        .PWRSTAT   (PWRSTAT),
        .MRST      (MRST),
        .nEMUEN    (nEMUEN),
        .nTEMPEN   (nTEMPEN),
        .nUSBEN    (nUSBEN),
        .nLED_PWROK(nLED_PWROK),
        .STATE     (STATE)
    );

    assign en = {nEMUEN, nTEMPEN, nUSBEN};

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge MCLK);
            #1;
        end
    endtask

    task automatic drain_led(input string tag);
        logic [7:0] e;
        while (exp_q.size() > 0) begin
            tick(1);
            e = exp_q.pop_front();
            check(tag, {7'd0, nLED_PWROK}, e);
        end
    endtask

    initial begin
        nRESET  = 1'b1;
        PWRSTAT = 1'b0;
        MRST    = 1'b0;
        #2;
        nRESET  = 1'b0;

        // reset values
        tick(2);
        check("rst_state", {5'd0, STATE}, 8'h00);
        check("rst_en", {5'd0, en}, 8'h07);
        check("rst_led", {7'd0, nLED_PWROK}, 8'h01);

        // release with board power: 001 at edge 8, 011 at 9, enables at 10
        nRESET = 1'b1;
        tick(7);
        check("boot_e7_state", {5'd0, STATE}, 8'h00);
        tick(1);
        check("boot_e8_state", {5'd0, STATE}, 8'h01);
        tick(1);
        check("boot_e9_state", {5'd0, STATE}, 8'h03);
        check("boot_e9_en", {5'd0, en}, 8'h07);
        tick(1);
        check("boot_e10_en", {5'd0, en}, 8'h00);
        check("boot_e10_led", {7'd0, nLED_PWROK}, 8'h00);

        // 3-cycle MRST glitch is filtered
        MRST = 1'b1;
        tick(3);
        MRST = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("glitch_state", {5'd0, STATE}, 8'h03);
            check("glitch_en", {5'd0, en}, 8'h00);
        end

        // MRST held: 000 at edge 7, enables off at 8, then ERROR_S0 at 9
        MRST = 1'b1;
        tick(6);
        check("mrst_e6_state", {5'd0, STATE}, 8'h03);
        tick(1);
        check("mrst_e7_state", {5'd0, STATE}, 8'h00);
        check("mrst_e7_en", {5'd0, en}, 8'h00);
        tick(1);
        check("mrst_e8_en", {5'd0, en}, 8'h07);
        check("mrst_e8_state", {5'd0, STATE}, 8'h01);
        tick(1);
        check("err0_state", {5'd0, STATE}, 8'h06);
        exp_q = '{8'h1, 8'h1, 8'h1, 8'h0, 8'h0, 8'h0, 8'h1, 8'h1, 8'h1};
        drain_led("err0_led");

        // MRST released: back to emulator
        MRST = 1'b0;
        tick(6);
        check("err0x_e6_state", {5'd0, STATE}, 8'h06);
        tick(1);
        check("err0x_e7_state", {5'd0, STATE}, 8'h00);
        tick(1);
        check("err0x_e8_state", {5'd0, STATE}, 8'h01);
        tick(1);
        check("err0x_e9_state", {5'd0, STATE}, 8'h03);
        tick(1);
        check("err0x_e10_en", {5'd0, en}, 8'h00);

        // USB only: ERROR_S1 with 6-cycle half-period
        PWRSTAT = 1'b1;
        tick(7);
        check("err1_e7_state", {5'd0, STATE}, 8'h00);
        tick(2);
        check("err1_state", {5'd0, STATE}, 8'h07);
        check("err1_en", {5'd0, en}, 8'h07);
        exp_q = '{8'h1, 8'h1, 8'h1, 8'h1, 8'h1, 8'h1,
                  8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h1};
        drain_led("err1_led");

        // USB and no board: MPSSE standby, USB core only
        MRST = 1'b1;
        tick(7);
        check("mpsse_e7_state", {5'd0, STATE}, 8'h00);
        tick(2);
        check("mpsse_state", {5'd0, STATE}, 8'h05);
        tick(1);
        check("mpsse_en", {5'd0, en}, 8'h06);
        check("mpsse_led", {7'd0, nLED_PWROK}, 8'h00);

        // both back to 0: MPSSE exits to emulator
        PWRSTAT = 1'b0;
        MRST    = 1'b0;
        tick(7);
        check("emu2_e7_state", {5'd0, STATE}, 8'h00);
        tick(2);
        check("emu2_state", {5'd0, STATE}, 8'h03);
        tick(1);
        check("emu2_en", {5'd0, en}, 8'h00);

        // asynchronous reset between edges
        @(negedge MCLK);
        #2;
        nRESET = 1'b0;
        #1;
        check("arst_en", {5'd0, en}, 8'h07);
        check("arst_state", {5'd0, STATE}, 8'h00);
        check("arst_led", {7'd0, nLED_PWROK}, 8'h01);
        tick(1);
        nRESET = 1'b1;
        tick(7);
        check("requal_e7_state", {5'd0, STATE}, 8'h00);
        tick(1);
        check("requal_e8_state", {5'd0, STATE}, 8'h01);
        tick(1);
        check("requal_e9_state", {5'd0, STATE}, 8'h03);
        tick(1);
        check("requal_e10_en", {5'd0, en}, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
